park_sensor_array: RTL and testbench
====================================

PARK_SENSOR_ARRAY -- requirements
Module: park_sensor_array

Interface
REQ-001 Parameter N_CH, default 4, number of joystick sensor channels (legal 1..8).
REQ-002 Parameter CLK_HZ, default 100000000, clk frequency in Hz.
REQ-003 Parameter SAMPLE_HZ, default 30, full-array scan rate in Hz.
REQ-004 Parameter SCLK_HALF, default 50, SCLK half-period in clk cycles (1 MHz at default).
REQ-005 Parameter GAP_CYC, default 1500, idle clk cycles between bytes and after SS assertion (15 us).
REQ-006 Parameter X_THRESH, default 10'd700, X reading at or above which a spot counts as occupied.
REQ-007 Parameter DEBOUNCE, default 3, consecutive agreeing samples required to change parked.
REQ-008 clk  input  1  system clock; all logic on its rising edge.
REQ-009 rst  input  1  synchronous reset, active-high.
REQ-010 MISO  input  1  shared serial data from all sensors.
REQ-011 SS  output  N_CH  per-channel chip select, active-low.
REQ-012 SCLK  output  1  shared serial clock, idle low (SPI mode 0).
REQ-013 MOSI  output  1  shared serial command data.
REQ-014 parked  output  N_CH  debounced occupancy per channel.
REQ-015 sample_valid  output  1  one-cycle pulse when a channel transaction completes.
REQ-016 sample_ch  output  3  channel index of the completed sample.
REQ-017 sample_data  output  40  raw 5-byte frame of the completed sample, byte 0 in bits 7:0.

Function
REQ-018 Tick counter SHALL pulse once per CLK_HZ/(SAMPLE_HZ*N_CH) cycles; each tick starts one channel's transaction.
REQ-019 FSM states SHALL be IDLE, SETUP, SHIFT, GAP, DONE.
REQ-020 IDLE->SETUP on tick: drive SS[ch] low and hold for GAP_CYC cycles.
REQ-021 SETUP->SHIFT: exchange 8 bits MSB first; MOSI changes on SCLK falling edge, MISO sampled on SCLK rising edge.
REQ-022 After each byte: if fewer than 5 bytes done, SHIFT->GAP (GAP_CYC cycles, SCLK low) then GAP->SHIFT; else SHIFT->DONE.
REQ-023 DONE: SS[ch] high, sample_valid high one cycle with sample_ch and sample_data, ch increments modulo N_CH, DONE->IDLE.
REQ-024 Transmitted byte 0 SHALL be {6'b100000, 1'b0, parked[ch]} (LED1 mirrors occupancy); bytes 1..4 SHALL be 8'h00.
REQ-025 Received frame: X = {byte1[1:0], byte0}, button = byte4[0]; raw occupancy = button OR (X >= X_THRESH).
REQ-026 At most one SS bit SHALL be low at any time; SS SHALL change only in IDLE/DONE transitions.
REQ-027 A tick arriving while not in IDLE SHALL be dropped, not queued.
REQ-028 sample_valid, sample_ch, sample_data SHALL hold their last values between pulses.

Reset
REQ-029 rst SHALL force IDLE, ch=0, tick counter 0, SS all ones, SCLK 0, MOSI 0, parked 0, sample_valid 0, sample_ch 0, sample_data 0, debounce counters 0.
REQ-030 rst mid-transaction SHALL abort it within one cycle with no sample_valid pulse.

Configuration
REQ-031 Macro PARK_SENSOR_DEBOUNCE_EN defined: per-channel counter SHALL require DEBOUNCE consecutive raw samples differing from parked before parked toggles; an agreeing sample clears the counter.
REQ-032 Macro undefined: parked[ch] SHALL load raw occupancy in the DONE cycle; no counters instantiated.

Structure
REQ-033 Shared package park_pkg SHALL hold the FSM state encoding, JSTK_BYTES=5, JSTK_LED_CMD=6'b100000 and the frame-field bit positions.
REQ-034 One sub-module spi_byte_xfer (8-bit mode-0 shift engine with start/done handshake and SCLK_HALF parameter) SHALL perform SHIFT.

Verification
REQ-035 rst held 5 cycles then released -> SS=all ones, parked=0, first SS[0] low after one tick period.
REQ-036 Sensor model on ch 2 returns X=10'd800 -> sample_valid with sample_ch=2, sample_data[9:0]=800; parked[2]=1 after 3 scans (DEBOUNCE_EN) or 1 scan (not).
REQ-037 Ch 1 frames alternate occupied/free with DEBOUNCE_EN -> parked[1] stays 0.
REQ-038 parked[0]=1 -> next ch 0 byte 0 on MOSI equals 8'h81; ch 0 free -> 8'h80.
REQ-039 rst asserted during byte 3 of ch 3 -> SS all ones next cycle, no sample_valid, restart at ch 0.
REQ-040 N_CH=1, X=699 then X=700 -> raw occupancy 0 then 1 (threshold boundary).

Source files
------------

// File: rtl/park_sensor_array_pkg.sv
// Shared definitions for the joystick-sensor parking array: scan FSM states,
// JSTK command constants and receive-frame field positions.
package park_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam int          JSTK_BYTES   = 5;
  localparam logic [5:0]  JSTK_LED_CMD = 6'b100000;

  // X spans byte0 and byte1[1:0], which are contiguous in the 40-bit frame
  localparam int X_LSB   = 0;
  localparam int X_W     = 10;
  localparam int BTN_BIT = 32;

  function automatic logic [X_W-1:0] frame_x(input logic [8*JSTK_BYTES-1:0] f);
    return f[X_LSB +: X_W];
  endfunction

  function automatic logic frame_btn(input logic [8*JSTK_BYTES-1:0] f);
    return f[BTN_BIT];
  endfunction

endpackage

// File: rtl/park_sensor_array_spi_byte_xfer.sv
// 8-bit SPI mode-0 shift engine: start loads a byte, done pulses once the
// eighth SCLK falling edge has been issued; rx_byte is valid with done.
module spi_byte_xfer #(
  parameter int SCLK_HALF = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       done,
  output logic [7:0] rx_byte
);

  localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  logic          busy_q, busy_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          done_q, done_d;
  logic [HW-1:0] half_cnt_q, half_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;

  always_comb begin
    busy_d     = busy_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    done_d     = 1'b0;
    half_cnt_d = half_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    if (!busy_q) begin
      if (start) begin
        busy_d     = 1'b1;
        tx_d       = tx_byte;
        mosi_d     = tx_byte[7];
        sclk_d     = 1'b0;
        half_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    end else if (half_cnt_q == HW'(SCLK_HALF - 1)) begin
      half_cnt_d = '0;
      if (!sclk_q) begin
        sclk_d = 1'b1;
        rx_d   = {rx_q[6:0], miso};
      end else begin
        sclk_d = 1'b0;
        if (bit_cnt_q == 3'd7) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          mosi_d = 1'b0;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          tx_d      = {tx_q[6:0], 1'b0};
          mosi_d    = tx_q[6];
        end
      end
    end else begin
      half_cnt_d = half_cnt_q + HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      done_q     <= 1'b0;
      half_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
    end else begin
      busy_q     <= busy_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      done_q     <= done_d;
      half_cnt_q <= half_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
    end
  end

  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign done    = done_q;
  assign rx_byte = rx_q;

endmodule

// File: rtl/park_sensor_array.sv
// Round-robin SPI scanner of N_CH joystick sensors producing per-spot occupancy.
// Define PARK_SENSOR_DEBOUNCE_EN to require DEBOUNCE agreeing samples per change.
module park_sensor_array #(
  parameter int         N_CH      = 4,
  parameter int         CLK_HZ    = 100000000,
  parameter int         SAMPLE_HZ = 30,
  parameter int         SCLK_HALF = 50,
  parameter int         GAP_CYC   = 1500,
  parameter logic [9:0] X_THRESH  = 10'd700,
  parameter int         DEBOUNCE  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MISO,
  output logic [N_CH-1:0] SS,
  output logic            SCLK,
  output logic            MOSI,
  output logic [N_CH-1:0] parked,
  output logic            sample_valid,
  output logic [2:0]      sample_ch,
  output logic [39:0]     sample_data
);

  import park_pkg::*;

  localparam int TICK_DIV = CLK_HZ / (SAMPLE_HZ * N_CH);
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_e          state_q, state_d;
  logic [31:0]     tick_cnt_q, tick_cnt_d;
  logic [31:0]     gap_cnt_q, gap_cnt_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [2:0]      byte_idx_q, byte_idx_d;
  logic [39:0]     frame_q, frame_d;
  logic [N_CH-1:0] ss_q, ss_d;
  logic [N_CH-1:0] parked_q, parked_d;
  logic            sample_valid_q, sample_valid_d;
  logic [2:0]      sample_ch_q, sample_ch_d;
  logic [39:0]     sample_data_q, sample_data_d;

  logic       tick, raw_occ;
  logic       xfer_start, xfer_done;
  logic [7:0] xfer_tx, xfer_rx;

  always_comb begin
    tick       = (tick_cnt_q == 32'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 32'd1;
    raw_occ    = frame_btn(frame_q) | (frame_x(frame_q) >= X_THRESH);
    xfer_tx    = (byte_idx_q == '0) ? {JSTK_LED_CMD, 1'b0, parked_q[ch_q]} : 8'h00;
  end

  always_comb begin
    state_d        = state_q;
    gap_cnt_d      = gap_cnt_q;
    ch_d           = ch_q;
    byte_idx_d     = byte_idx_q;
    frame_d        = frame_q;
    ss_d           = ss_q;
    sample_valid_d = 1'b0;
    sample_ch_d    = sample_ch_q;
    sample_data_d  = sample_data_q;
    xfer_start     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // ticks outside IDLE are simply not looked at, so they are dropped
        if (tick) begin
          ss_d       = ~(N_CH'(1) << ch_q);
          gap_cnt_d  = '0;
          byte_idx_d = '0;
          frame_d    = '0;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP, ST_GAP: begin
        if (gap_cnt_q == 32'(GAP_CYC - 1)) begin
          xfer_start = 1'b1;
          gap_cnt_d  = '0;
          state_d    = ST_SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q + 32'd1;
        end
      end
      ST_SHIFT: begin
        if (xfer_done) begin
          frame_d[{byte_idx_q, 3'b000} +: 8] = xfer_rx;
          if (byte_idx_q == 3'(JSTK_BYTES - 1)) begin
            state_d = ST_DONE;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            state_d    = ST_GAP;
          end
        end
      end
      ST_DONE: begin
        ss_d           = '1;
        sample_valid_d = 1'b1;
        sample_ch_d    = 3'(ch_q);
        sample_data_d  = frame_q;
        ch_d           = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + CH_W'(1);
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef PARK_SENSOR_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE + 1);

  logic [DB_W-1:0] db_cnt_q [N_CH];
  logic [DB_W-1:0] db_cnt_d [N_CH];

  always_comb begin
    parked_d = parked_q;
    db_cnt_d = db_cnt_q;
    if (state_q == ST_DONE) begin
      if (raw_occ != parked_q[ch_q]) begin
        if (db_cnt_q[ch_q] == DB_W'(DEBOUNCE - 1)) begin
          parked_d[ch_q] = raw_occ;
          db_cnt_d[ch_q] = '0;
        end else begin
          db_cnt_d[ch_q] = db_cnt_q[ch_q] + DB_W'(1);
        end
      end else begin
        db_cnt_d[ch_q] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) db_cnt_q <= '{default: '0};
    else     db_cnt_q <= db_cnt_d;
  end
`else
  always_comb begin
    parked_d = parked_q;
    if (state_q == ST_DONE) parked_d[ch_q] = raw_occ;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      tick_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      ch_q           <= '0;
      byte_idx_q     <= '0;
      frame_q        <= '0;
      ss_q           <= '1;
      parked_q       <= '0;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= '0;
      sample_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      ch_q           <= ch_d;
      byte_idx_q     <= byte_idx_d;
      frame_q        <= frame_d;
      ss_q           <= ss_d;
      parked_q       <= parked_d;
      sample_valid_q <= sample_valid_d;
      sample_ch_q    <= sample_ch_d;
      sample_data_q  <= sample_data_d;
    end
  end

  spi_byte_xfer #(.SCLK_HALF(SCLK_HALF)) u_spi (
    .clk     (clk),
    .rst     (rst),
    .start   (xfer_start),
    .tx_byte (xfer_tx),
    .miso    (MISO),
    .sclk    (SCLK),
    .mosi    (MOSI),
    .done    (xfer_done),
    .rx_byte (xfer_rx)
  );

  assign SS           = ss_q;
  assign parked       = parked_q;
  assign sample_valid = sample_valid_q;
  assign sample_ch    = sample_ch_q;
  assign sample_data  = sample_data_q;

endmodule

// File: tb/tb_park_sensor_array.sv
// Scoreboard bench for park_sensor_array: sensor models serve frames on SS fall
// and push the expected sample; tasks pop and compare when sample_valid pulses.
module tb_park_sensor_array;

  localparam int N_CH      = 4;
  localparam int CLK_HZ    = 1200;
  localparam int SAMPLE_HZ = 1;
  localparam int SCLK_HALF = 2;
  localparam int GAP_CYC   = 4;
  localparam int DEBOUNCE  = 3;
  localparam int TICK      = CLK_HZ / (SAMPLE_HZ * N_CH);
  localparam int TMO       = 2 * TICK;

  typedef struct {
    logic [2:0]  ch;
    logic [39:0] frame;
    logic [7:0]  mosi;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            MISO = 1'b0;
  logic [N_CH-1:0] SS, parked;
  logic            SCLK, MOSI, sample_valid;
  logic [2:0]      sample_ch;
  logic [39:0]     sample_data;

  logic       MISO1 = 1'b0;
  logic [0:0] SS1, parked1;
  logic       SCLK1, MOSI1, sample_valid1;
  logic [2:0] sample_ch1;
  logic [39:0] sample_data1;

  int tests = 0;
  int fails = 0;

  logic [9:0]      x_val [N_CH];
  logic            btn   [N_CH];
  logic [9:0]      x1 = 10'd699;
  logic [N_CH-1:0] p_model = '0;
  int              cnt_m [N_CH];
  exp_t            sb [$];
  exp_t            e_new;

  logic [39:0]     stream, stream1;
  int              bit_idx, bit_idx1, sclk_rises, mosi_n;
  logic [7:0]      mosi_sh, last_b0;
  logic [N_CH-1:0] ss_prev = '1;
  logic            ss1_prev = 1'b1;

  park_sensor_array #(
    .N_CH(N_CH), .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .SCLK_HALF(SCLK_HALF),
    .GAP_CYC(GAP_CYC), .X_THRESH(10'd700), .DEBOUNCE(DEBOUNCE)
  ) u_dut (
    .clk(clk), .rst(rst), .MISO(MISO), .SS(SS), .SCLK(SCLK), .MOSI(MOSI),
    .parked(parked), .sample_valid(sample_valid), .sample_ch(sample_ch),
    .sample_data(sample_data)
  );

  park_sensor_array #(
    .N_CH(1), .CLK_HZ(300), .SAMPLE_HZ(1), .SCLK_HALF(SCLK_HALF),
    .GAP_CYC(GAP_CYC), .X_THRESH(10'd700), .DEBOUNCE(DEBOUNCE)
  ) u_dut1 (
    .clk(clk), .rst(rst), .MISO(MISO1), .SS(SS1), .SCLK(SCLK1), .MOSI(MOSI1),
    .parked(parked1), .sample_valid(sample_valid1), .sample_ch(sample_ch1),
    .sample_data(sample_data1)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] mk_frame(input logic [9:0] x, input logic b);
    return {7'b0, b, 16'h0000, 6'b0, x};
  endfunction

  // serial order: byte 0 first, each byte MSB first
  function automatic logic sbit(input logic [39:0] f, input int k);
    logic [39:0] t;
    t = f >> ((k / 8) * 8 + 7 - (k % 8));
    return t[0];
  endfunction

  always @(SS) begin
    for (int c = 0; c < N_CH; c++) begin
      if (ss_prev[c] === 1'b1 && SS[c] === 1'b0) begin
        stream      = mk_frame(x_val[c], btn[c]);
        e_new.ch    = 3'(c);
        e_new.frame = stream;
        e_new.mosi  = {7'b1000000, p_model[c]};
        sb.push_back(e_new);
        bit_idx    = 0;
        mosi_n     = 0;
        sclk_rises = 0;
        MISO       = sbit(stream, 0);
      end
    end
    ss_prev = SS;
  end

  always @(negedge SCLK) begin
    if (SS !== '1) begin
      bit_idx++;
      if (bit_idx < 40) MISO = sbit(stream, bit_idx);
    end
  end

  always @(posedge SCLK) begin
    if (SS !== '1) begin
      sclk_rises++;
      if (mosi_n < 8) begin
        mosi_sh = {mosi_sh[6:0], MOSI};
        mosi_n++;
        if (mosi_n == 8) last_b0 = mosi_sh;
      end
    end
  end

  always @(SS1) begin
    if (ss1_prev === 1'b1 && SS1[0] === 1'b0) begin
      stream1  = mk_frame(x1, 1'b0);
      bit_idx1 = 0;
      MISO1    = sbit(stream1, 0);
    end
    ss1_prev = SS1[0];
  end

  always @(negedge SCLK1) begin
    if (SS1[0] === 1'b0) begin
      bit_idx1++;
      if (bit_idx1 < 40) MISO1 = sbit(stream1, bit_idx1);
    end
  end

  task automatic clear_model();
    sb.delete();
    p_model = '0;
    for (int c = 0; c < N_CH; c++) cnt_m[c] = 0;
  endtask

  task automatic check_sample(output logic [2:0] ch_o, output logic [39:0] d_o,
                              output logic [7:0] mb_o);
    int   n, ci;
    exp_t e;
    logic raw;
    n = 0; ch_o = 3'd7; d_o = '0; mb_o = '0;
    do begin @(negedge clk); n++; end while (sample_valid !== 1'b1 && n < TMO);
    tests++;
    if (sample_valid !== 1'b1) begin
      fails++;
      $display("FAIL sample_timeout: sample_valid=%b after %0d cycles, required 1", sample_valid, n);
      return;
    end
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL sb_empty: sample ch=%0d arrived, required a launched transaction", sample_ch);
      return;
    end
    e = sb.pop_front();
    ch_o = sample_ch; d_o = sample_data; mb_o = last_b0;
    tests++;
    if (sample_ch !== e.ch) begin
      fails++; $display("FAIL sample_ch: got %0d, required %0d", sample_ch, e.ch);
    end
    tests++;
    if (sample_data !== e.frame) begin
      fails++; $display("FAIL sample_data: got %h, required %h", sample_data, e.frame);
    end
    tests++;
    if (last_b0 !== e.mosi) begin
      fails++; $display("FAIL mosi_byte0 ch%0d: got %h, required %h", e.ch, last_b0, e.mosi);
    end
    ci  = int'(e.ch);
    raw = e.frame[32] | (e.frame[9:0] >= 10'd700);
`ifdef PARK_SENSOR_DEBOUNCE_EN
    if (raw != p_model[ci]) begin
      cnt_m[ci]++;
      if (cnt_m[ci] == DEBOUNCE) begin p_model[ci] = raw; cnt_m[ci] = 0; end
    end else begin
      cnt_m[ci] = 0;
    end
`else
    p_model[ci] = raw;
`endif
    tests++;
    if (parked !== p_model) begin
      fails++; $display("FAIL parked: got %b, required %b", parked, p_model);
    end
    @(negedge clk);
    tests++;
    if (sample_valid !== 1'b0 || sample_data !== e.frame) begin
      fails++;
      $display("FAIL sample_hold: valid=%b data=%h, required 0 and %h", sample_valid, sample_data, e.frame);
    end
  endtask

  task automatic wait_first_ss(input string name);
    int n;
    n = 0;
    do begin @(posedge clk); @(negedge clk); n++; end while (SS === '1 && n < TMO);
    tests++;
    if (SS !== 4'b1110) begin
      fails++; $display("FAIL %s_ss: got %b, required 1110", name, SS);
    end
    tests++;
    if (n != TICK) begin
      fails++; $display("FAIL %s_tick: SS fell after %0d cycles, required %0d", name, n, TICK);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    tests++; if (SS !== 4'b1111) begin fails++; $display("FAIL rst_ss: got %b, required 1111", SS); end
    tests++; if (parked !== 4'b0000) begin fails++; $display("FAIL rst_parked: got %b, required 0000", parked); end
    tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b, required 0", sample_valid); end
    tests++; if (sample_ch !== 3'd0) begin fails++; $display("FAIL rst_ch: got %0d, required 0", sample_ch); end
    tests++; if (sample_data !== 40'd0) begin fails++; $display("FAIL rst_data: got %h, required 0", sample_data); end
    tests++; if (SCLK !== 1'b0 || MOSI !== 1'b0) begin fails++; $display("FAIL rst_spi: sclk=%b mosi=%b, required 0 0", SCLK, MOSI); end
    clear_model();
    rst = 1'b0;
    wait_first_ss("rst");
  endtask

  task automatic test_ch2_occupied();
    logic [2:0] ch; logic [39:0] d; logic [7:0] mb;
    x_val[2] = 10'd800;
    for (int i = 0; i < 3 * N_CH; i++) begin
      check_sample(ch, d, mb);
      if (ch == 3'd2) begin
        tests++;
        if (d[9:0] !== 10'd800) begin fails++; $display("FAIL ch2_x: got %0d, required 800", d[9:0]); end
      end
    end
    tests++;
    if (parked[2] !== 1'b1) begin fails++; $display("FAIL ch2_parked: got %b, required 1", parked[2]); end
  endtask

  task automatic test_ch1_alternate();
    logic [2:0] ch; logic [39:0] d; logic [7:0] mb;
    logic last_raw;
    last_raw = 1'b0;
    for (int i = 0; i < 4 * N_CH; i++) begin
      check_sample(ch, d, mb);
      if (ch == 3'd1) begin
        last_raw = (d[9:0] >= 10'd700);
        x_val[1] = (x_val[1] == 10'd100) ? 10'd800 : 10'd100;
      end
    end
    tests++;
`ifdef PARK_SENSOR_DEBOUNCE_EN
    if (parked[1] !== 1'b0) begin fails++; $display("FAIL ch1_alt: got %b, required 0", parked[1]); end
`else
    if (parked[1] !== last_raw) begin fails++; $display("FAIL ch1_alt: got %b, required %b", parked[1], last_raw); end
`endif
    x_val[1] = 10'd100;
  endtask

  task automatic test_mosi_led();
    logic [2:0] ch; logic [39:0] d; logic [7:0] mb;
    logic seen, hit;
    x_val[0] = 10'd900;
    seen = 1'b0; hit = 1'b0;
    for (int i = 0; i < 8 * N_CH && !hit; i++) begin
      check_sample(ch, d, mb);
      if (ch == 3'd0) begin
        if (seen) begin
          hit = 1'b1;
          tests++;
          if (mb !== 8'h81) begin fails++; $display("FAIL led_on: got %h, required 81", mb); end
        end else if (parked[0] === 1'b1) seen = 1'b1;
      end
    end
    tests++;
    if (!hit) begin fails++; $display("FAIL led_on_reach: parked[0]=%b, required 1 then a ch0 frame", parked[0]); end
    x_val[0] = 10'd100;
    seen = 1'b0; hit = 1'b0;
    for (int i = 0; i < 8 * N_CH && !hit; i++) begin
      check_sample(ch, d, mb);
      if (ch == 3'd0) begin
        if (seen) begin
          hit = 1'b1;
          tests++;
          if (mb !== 8'h80) begin fails++; $display("FAIL led_off: got %h, required 80", mb); end
        end else if (parked[0] === 1'b0) seen = 1'b1;
      end
    end
    tests++;
    if (!hit) begin fails++; $display("FAIL led_off_reach: parked[0]=%b, required 0 then a ch0 frame", parked[0]); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] ch; logic [39:0] d; logic [7:0] mb;
    int n;
    ch = 3'd7;
    for (int i = 0; i < 2 * N_CH && ch != 3'd2; i++) check_sample(ch, d, mb);
    n = 0;
    while (SS[3] !== 1'b0 && n < TMO) begin @(negedge clk); n++; end
    tests++;
    if (SS[3] !== 1'b0) begin fails++; $display("FAIL mid_ss3: got %b, required 0", SS[3]); end
    n = 0;
    while (sclk_rises < 26 && n < TMO) begin @(negedge clk); n++; end
    tests++;
    if (sclk_rises < 26) begin fails++; $display("FAIL mid_byte3: sclk rises %0d, required 26", sclk_rises); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    tests++; if (SS !== 4'b1111) begin fails++; $display("FAIL mid_ss: got %b, required 1111", SS); end
    tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b, required 0", sample_valid); end
    tests++; if (SCLK !== 1'b0) begin fails++; $display("FAIL mid_sclk: got %b, required 0", SCLK); end
    @(posedge clk); @(negedge clk);
    tests++; if (sample_valid !== 1'b0 || parked !== 4'b0000) begin
      fails++; $display("FAIL mid_hold: valid=%b parked=%b, required 0 0000", sample_valid, parked);
    end
    clear_model();
    rst = 1'b0;
    wait_first_ss("mid");
    check_sample(ch, d, mb);
    tests++;
    if (ch !== 3'd0) begin fails++; $display("FAIL mid_restart_ch: got %0d, required 0", ch); end
  endtask

  task automatic test_threshold();
    int   n;
    logic exp_p;
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < 3; k++) begin
        n = 0;
        do begin @(negedge clk); n++; end while (sample_valid1 !== 1'b1 && n < TMO);
        tests++;
        if (sample_valid1 !== 1'b1) begin
          fails++; $display("FAIL thr_timeout: sample_valid=%b after %0d cycles, required 1", sample_valid1, n);
        end
        tests++;
        if (sample_data1 !== mk_frame(x1, 1'b0) || sample_ch1 !== 3'd0) begin
          fails++; $display("FAIL thr_data: got ch%0d %h, required ch0 %h", sample_ch1, sample_data1, mk_frame(x1, 1'b0));
        end
`ifdef PARK_SENSOR_DEBOUNCE_EN
        exp_p = (ph == 1) && (k == 2);
`else
        exp_p = (ph == 1);
`endif
        tests++;
        if (parked1[0] !== exp_p) begin
          fails++; $display("FAIL thr_parked x=%0d k=%0d: got %b, required %b", x1, k, parked1[0], exp_p);
        end
      end
      x1 = 10'd700;
    end
  endtask

  initial begin
    for (int c = 0; c < N_CH; c++) begin
      x_val[c] = 10'd100;
      btn[c]   = 1'b0;
      cnt_m[c] = 0;
    end
    test_reset();
    test_ch2_occupied();
    test_ch1_alternate();
    test_mosi_led();
    test_reset_mid();
    test_threshold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
